// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: answers IF fetch requests, stalls
// flow control on a miss and refills whole lines over a req/ack + beat stream.
module icache_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc_i,
  input  logic        if_valid_req_i,
  input  logic        fc_jump_flag_i,
  output logic        icache_stall_o,
  output logic [31:0] icache_inst_o,
  output logic [31:0] icache_inst_pc_o,
  output logic        icache_inst_valid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;
  localparam int unsigned WRD_W = OFF_W - 2;
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DONE, S_PEND} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            miss_pc_q, miss_pc_d;
  logic [31:0]            pend_pc_q, pend_pc_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   drop_q, drop_d;
  logic [WRD_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            inst_q, inst_d;
  logic [31:0]            inst_pc_q, inst_pc_d;
  logic                   inst_valid_q, inst_valid_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]       tag_q    [NUM_LINES];
  logic [31:0]            data_q   [NUM_LINES][LINE_WORDS];
  logic [31:0]            fill_buf_q [LINE_WORDS];

  logic                   fill_we, line_we, stall_c, busy, lookup, hit;
  logic [31:0]            lookup_pc;
  logic [IDX_W-1:0]       lk_idx, miss_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [WRD_W-1:0]       lk_word;

  // Lookup source: live request in IDLE, the parked request in PEND.
  always_comb begin
    lookup_pc = (state_q == S_PEND) ? pend_pc_q : if_pc_i;
    lk_idx    = lookup_pc[OFF_W+IDX_W-1:OFF_W];
    lk_tag    = lookup_pc[31:OFF_W+IDX_W];
    lk_word   = lookup_pc[OFF_W-1:2];
    miss_idx  = miss_pc_q[OFF_W+IDX_W-1:OFF_W];
    lookup    = ((state_q == S_IDLE) && if_valid_req_i) || (state_q == S_PEND);
    hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    busy      = (state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_DONE);
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_vld_d   = pend_vld_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = 1'b0;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    line_we      = 1'b0;
    stall_c      = 1'b0;

    // Requests arriving during a refill are parked; a jump makes them and the refill stale.
    if (busy && if_valid_req_i) begin
      pend_pc_d  = if_pc_i;
      pend_vld_d = 1'b1;
    end
    if (busy && fc_jump_flag_i) begin
      drop_d     = 1'b1;
      pend_vld_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_PEND: begin
        if (lookup) begin
          pend_vld_d = 1'b0;
          if (hit) begin
            inst_valid_d = ~fc_jump_flag_i;
            inst_d       = data_q[lk_idx][lk_word];
            inst_pc_d    = lookup_pc;
            state_d      = S_IDLE;
          end else begin
            stall_c   = 1'b1;
            miss_pc_d = lookup_pc;
            drop_d    = fc_jump_flag_i;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (mem_ack_i) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        stall_c = 1'b1;
        if (mem_rvalid_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + WRD_W'(1);
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        stall_c           = pend_vld_q;
        line_we           = 1'b1;
        valid_d[miss_idx] = 1'b1;
        inst_valid_d      = ~drop_q & ~fc_jump_flag_i;
        inst_d            = fill_buf_q[miss_pc_q[OFF_W-1:2]];
        inst_pc_d         = miss_pc_q;
        drop_d            = 1'b0;
        state_d           = pend_vld_d ? S_PEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      miss_pc_q    <= '0;
      pend_pc_q    <= '0;
      pend_vld_q   <= 1'b0;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_vld_q   <= pend_vld_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      valid_q      <= valid_d;
    end
  end

  // Storage arrays: qualified by valid_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (fill_we) fill_buf_q[cnt_q] <= mem_rdata_i;
    if (line_we) begin
      tag_q[miss_idx] <= miss_pc_q[31:OFF_W+IDX_W];
      for (int w = 0; w < LINE_WORDS; w++) data_q[miss_idx][w] <= fill_buf_q[w];
    end
  end

  assign icache_stall_o      = stall_c;
  assign icache_inst_o       = inst_q;
  assign icache_inst_pc_o    = inst_pc_q;
  assign icache_inst_valid_o = inst_valid_q;
  assign mem_req_o           = (state_q == S_REQ);
  assign mem_addr_o          = {miss_pc_q[31:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: expected responses queued at request
// time, popped and compared by a negedge monitor.
module tb_icache_responder;

  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc_i;
  logic        if_valid_req_i;
  logic        fc_jump_flag_i;
  logic        icache_stall_o;
  logic [31:0] icache_inst_o;
  logic [31:0] icache_inst_pc_o;
  logic        icache_inst_valid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  icache_responder #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_pc_i             (if_pc_i),
    .if_valid_req_i      (if_valid_req_i),
    .fc_jump_flag_i      (fc_jump_flag_i),
    .icache_stall_o      (icache_stall_o),
    .icache_inst_o       (icache_inst_o),
    .icache_inst_pc_o    (icache_inst_pc_o),
    .icache_inst_valid_o (icache_inst_valid_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_ack_i           (mem_ack_i),
    .mem_rdata_i         (mem_rdata_i),
    .mem_rvalid_i        (mem_rvalid_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:0], 5'b0} | 32'h13;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every inst_valid pulse must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && icache_inst_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp inst=%h pc=%h", icache_inst_o, icache_inst_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (icache_inst_o !== e.inst || icache_inst_pc_o !== e.pc) begin
            failures++;
            $display("FAIL resp_data got inst=%h pc=%h want inst=%h pc=%h",
                     icache_inst_o, icache_inst_pc_o, e.inst, e.pc);
          end
        end
      end
    end
  endtask

  // One-cycle fetch request; returns the stall seen in the request cycle.
  task automatic fetch(input logic [31:0] pc, output logic stalled);
    if_valid_req_i = 1'b1;
    if_pc_i        = pc;
    @(negedge clk);
    stalled = icache_stall_o;
    tick();
    if_valid_req_i = 1'b0;
  endtask

  // Memory side: wait for a request, ack it, stream the line; optional jump and post-jump request.
  task automatic serve(input int gap, input int jump_beat, input logic [31:0] post_pc,
                       output logic [31:0] addr, output bit timeout);
    timeout = 1'b0;
    addr    = '0;
    for (int i = 0; i < 40 && mem_req_o !== 1'b1; i++) tick();
    if (mem_req_o !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    addr      = mem_addr_o;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) repeat (gap) tick();
      mem_rvalid_i   = 1'b1;
      mem_rdata_i    = mem_word(addr + 32'(4 * b));
      fc_jump_flag_i = (b == jump_beat);
      if_valid_req_i = (b == jump_beat + 1);
      if_pc_i        = post_pc;
      tick();
      mem_rvalid_i   = 1'b0;
      fc_jump_flag_i = 1'b0;
      if_valid_req_i = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain outstanding=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_pc_i = '0; if_valid_req_i = 1'b0; fc_jump_flag_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0; mem_rvalid_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({icache_stall_o, icache_inst_valid_o, mem_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got stall/valid/req=%b want 000",
               {icache_stall_o, icache_inst_valid_o, mem_req_o});
    end
    checks++;
    if (icache_inst_o !== 32'h0 || icache_inst_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got inst=%h pc=%h want 0 0", icache_inst_o, icache_inst_pc_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    logic [31:0] a; bit to;
    if_valid_req_i = 1'b1; if_pc_i = 32'h0;
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b1) begin
      failures++; $display("FAIL cold_stall got %b want 1", icache_stall_o);
    end
    exp_q.push_back('{inst: 32'h13, pc: 32'h0});
    tick();
    if_valid_req_i = 1'b0;
    serve(0, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'h0) begin
      failures++; $display("FAIL cold_req got timeout=%0d addr=%h want 0 00000000", to, a);
    end
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b0 || icache_inst_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL cold_done got stall=%b valid=%b want 0 0", icache_stall_o, icache_inst_valid_o);
    end
    @(negedge clk);
    checks++;
    if (icache_inst_valid_o !== 1'b1) begin
      failures++; $display("FAIL cold_latency got valid=%b want 1", icache_inst_valid_o);
    end
    drain("cold");
  endtask

  task automatic test_back_to_back();
    if_valid_req_i = 1'b1; if_pc_i = 32'h4;
    exp_q.push_back('{inst: 32'h93, pc: 32'h4});
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL hit1_ctrl got stall=%b req=%b want 0 0", icache_stall_o, mem_req_o);
    end
    tick();
    if_pc_i = 32'h8;
    exp_q.push_back('{inst: 32'h113, pc: 32'h8});
    @(negedge clk);
    checks++;
    if (icache_inst_valid_o !== 1'b1 || icache_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL hit2_ctrl got valid=%b stall=%b req=%b want 1 0 0",
               icache_inst_valid_o, icache_stall_o, mem_req_o);
    end
    tick();
    if_valid_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (icache_inst_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL hit2_latency got valid=%b req=%b want 1 0", icache_inst_valid_o, mem_req_o);
    end
    drain("hits");
  endtask

  task automatic test_conflict();
    logic st; logic [31:0] a; bit to;
    fetch(32'h100, st);
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL conflict_miss got stall=%b want 1", st); end
    exp_q.push_back('{inst: mem_word(32'h100), pc: 32'h100});
    serve(0, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'h100) begin
      failures++; $display("FAIL conflict_req got timeout=%0d addr=%h want 0 00000100", to, a);
    end
    drain("conflict_fill");
    fetch(32'h0, st);
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL evicted_miss got stall=%b want 1", st); end
    exp_q.push_back('{inst: 32'h13, pc: 32'h0});
    serve(0, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'h0) begin
      failures++; $display("FAIL evicted_req got timeout=%0d addr=%h want 0 00000000", to, a);
    end
    drain("conflict");
  endtask

  task automatic test_jump_fill();
    logic st; logic [31:0] a; bit to;
    fetch(32'h40, st);
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL jump_miss got stall=%b want 1", st); end
    serve(0, 2, 32'h80, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'h40) begin
      failures++; $display("FAIL jump_req got timeout=%0d addr=%h want 0 00000040", to, a);
    end
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b1) begin
      failures++; $display("FAIL jump_done_stall got %b want 1", icache_stall_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b1) begin
      failures++; $display("FAIL pend_miss_stall got %b want 1", icache_stall_o);
    end
    exp_q.push_back('{inst: mem_word(32'h80), pc: 32'h80});
    tick();
    serve(0, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'h80) begin
      failures++; $display("FAIL pend_req got timeout=%0d addr=%h want 0 00000080", to, a);
    end
    drain("jump");
    fetch(32'h44, st);
    exp_q.push_back('{inst: mem_word(32'h44), pc: 32'h44});
    checks++;
    if (st !== 1'b0) begin failures++; $display("FAIL dropped_line_hit got stall=%b want 0", st); end
    drain("jump_line");
  endtask

  task automatic test_gap_reset();
    logic st; logic [31:0] a; bit to;
    fetch(32'hC0, st);
    exp_q.push_back('{inst: mem_word(32'hC0), pc: 32'hC0});
    serve(3, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'hC0 || st !== 1'b1) begin
      failures++; $display("FAIL gap_req got timeout=%0d addr=%h stall=%b want 0 000000c0 1", to, a, st);
    end
    drain("gap");
    fetch(32'hC8, st);
    exp_q.push_back('{inst: mem_word(32'hC8), pc: 32'hC8});
    checks++;
    if (st !== 1'b0) begin failures++; $display("FAIL gap_hit got stall=%b want 0", st); end
    drain("gap_hit");
    // Refill of 0x200 interrupted by reset after two beats.
    fetch(32'h200, st);
    mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h200 + 32'(4 * b)); tick();
    end
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({icache_stall_o, icache_inst_valid_o, mem_req_o} !== 3'b000 || icache_inst_o !== 32'h0) begin
      failures++;
      $display("FAIL midfill_reset got stall/valid/req=%b inst=%h want 000 0",
               {icache_stall_o, icache_inst_valid_o, mem_req_o}, icache_inst_o);
    end
    tick();
    mem_rvalid_i = 1'b1; tick();
    rst_n = 1'b1; mem_ack_i = 1'b1; tick();
    mem_rvalid_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b0 || mem_req_o !== 1'b0 || icache_inst_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stray_ignored got stall=%b req=%b valid=%b want 0 0 0",
               icache_stall_o, mem_req_o, icache_inst_valid_o);
    end
    tick();
    fetch(32'hC0, st);
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL post_reset_miss got stall=%b want 1", st); end
    exp_q.push_back('{inst: mem_word(32'hC0), pc: 32'hC0});
    serve(0, NONE, '0, a, to);
    checks++;
    if (to !== 1'b0 || a !== 32'hC0) begin
      failures++; $display("FAIL post_reset_req got timeout=%0d addr=%h want 0 000000c0", to, a);
    end
    drain("post_reset");
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_jump_fill();
    test_gap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
